dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_sequencer.sv | 135 +++++++++++++
 tb/tb_dispense_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// Drink dispense sequencer: cup drop, timed pour, wait for cup removal, with a
// small paid-request queue, sticky overflow flag and a completed-drink counter.
module dispense_sequencer #(
  parameter int CUP_CYCLES  = 4,
  parameter int POUR_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dispense_req,
  input  logic       cup_present,
  input  logic       fault_clr,
  output logic       cup_motor,
  output logic       pour_valve,
  output logic       busy,
  output logic       fault,
  output logic [1:0] pending,
  output logic       overflow,
  output logic [7:0] dispensed_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CUP   = 3'd1,
    S_POUR  = 3'd2,
    S_WAIT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [7:0] CUP_LAST  = 8'(CUP_CYCLES - 1);
  localparam logic [7:0] POUR_LAST = 8'(POUR_CYCLES - 1);

  state_t     state_r, state_s;
  logic [7:0] timer_r, timer_s;
  logic [1:0] pending_s;
  logic       overflow_s;
  logic [7:0] count_s;
  logic       inc_s, dec_s;

  // Next-state, phase timer, request queue and drink counter.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    pending_s  = pending;
    overflow_s = overflow;
    count_s    = dispensed_count;
    // A request arriving in IDLE with an empty queue starts the drink directly.
    dec_s = (state_r == S_IDLE) && (pending != 2'd0);
    inc_s = dispense_req && !((state_r == S_IDLE) && (pending == 2'd0));

    case (state_r)
      S_IDLE: begin
        if (dispense_req || (pending != 2'd0)) begin
          state_s = S_CUP;
          timer_s = 8'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CUP: begin
        if (timer_r == CUP_LAST) begin
          timer_s = 8'd0;
          state_s = cup_present ? S_POUR : S_FAULT;
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      S_POUR: begin
        if (timer_r == POUR_LAST) begin
          timer_s = 8'd0;
          state_s = S_WAIT;
          count_s = dispensed_count + 8'd1;
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      S_WAIT: begin
        if (!cup_present) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_FAULT;
        end
      end
      default: begin
        state_s = S_IDLE;
        timer_s = 8'd0;
      end
    endcase

    // Simultaneous increment and decrement cancel out.
    if (inc_s && !dec_s) begin
      if (pending == 2'd3) begin
        overflow_s = 1'b1;
      end else begin
        pending_s = pending + 2'd1;
      end
    end else if (dec_s && !inc_s) begin
      pending_s = pending - 2'd1;
    end else begin
      pending_s = pending;
    end
  end

  // State, counters and registered output decode of the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      timer_r         <= 8'd0;
      pending         <= 2'd0;
      overflow        <= 1'b0;
      dispensed_count <= 8'd0;
      cup_motor       <= 1'b0;
      pour_valve      <= 1'b0;
      busy            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_r         <= state_s;
      timer_r         <= timer_s;
      pending         <= pending_s;
      overflow        <= overflow_s;
      dispensed_count <= count_s;
      cup_motor       <= (state_s == S_CUP);
      pour_valve      <= (state_s == S_POUR);
      busy            <= (state_s != S_IDLE);
      fault           <= (state_s == S_FAULT);
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Scoreboard bench for dispense_sequencer: stimulus pushes expected output
// snapshots tagged with a cycle number; a negedge monitor pops and compares.
module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       dispense_req;
  logic       cup_present;
  logic       fault_clr;
  logic       cup_motor;
  logic       pour_valve;
  logic       busy;
  logic       fault;
  logic [1:0] pending;
  logic       overflow;
  logic [7:0] dispensed_count;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int          cyc;
    string       nm;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];

  dispense_sequencer #(.CUP_CYCLES(4), .POUR_CYCLES(6)) dut (
    .clk(clk),
    .rst(rst),
    .dispense_req(dispense_req),
    .cup_present(cup_present),
    .fault_clr(fault_clr),
    .cup_motor(cup_motor),
    .pour_valve(pour_valve),
    .busy(busy),
    .fault(fault),
    .pending(pending),
    .overflow(overflow),
    .dispensed_count(dispensed_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    logic [14:0] got;
    got = {cup_motor, pour_valve, busy, fault, pending, overflow, dispensed_count};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks = checks + 1;
        if (got === sb[i].v) begin
          passes = passes + 1;
        end else begin
          $display("FAIL %s cyc=%0d got{cm,pv,bz,ft,pd,ov,dc}=%b_%b_%b_%b_%0d_%b_%0d required=%b_%b_%b_%b_%0d_%b_%0d",
                   sb[i].nm, cyc, got[14], got[13], got[12], got[11], got[10:9], got[8], got[7:0],
                   sb[i].v[14], sb[i].v[13], sb[i].v[12], sb[i].v[11], sb[i].v[10:9], sb[i].v[8], sb[i].v[7:0]);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int t, input string nm, input logic cm, input logic pv,
                      input logic bz, input logic ft, input logic [1:0] pd,
                      input logic ov, input logic [7:0] dc);
    exp_t e;
    e.cyc = t;
    e.nm  = nm;
    e.v   = {cm, pv, bz, ft, pd, ov, dc};
    sb.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string nm);
    rst          = 1'b1;
    dispense_req = 1'b0;
    fault_clr    = 1'b0;
    cup_present  = 1'b0;
    wait_to(cyc + 1);
    rst = 1'b0;
    push(cyc, nm, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int e;
    rst          = 1'b1;
    dispense_req = 1'b0;
    cup_present  = 1'b0;
    fault_clr    = 1'b0;
    wait_to(2);
    rst = 1'b0;
    push(cyc, "reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);

    // Single drink: 4 cup cycles, 6 pour cycles, removal 3 cycles after pour.
    wait_to(cyc + 1);
    b = cyc;
    cup_present  = 1'b1;
    dispense_req = 1'b1;
    for (int d = 1; d <= 4; d++) push(b + d, "s1_cup", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    for (int d = 5; d <= 10; d++) push(b + d, "s1_pour", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    for (int d = 11; d <= 13; d++) push(b + d, "s1_wait", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd1);
    push(b + 14, "s1_removed", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);
    push(b + 16, "s1_idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);
    wait_to(b + 1);
    dispense_req = 1'b0;
    wait_to(b + 13);
    cup_present = 1'b0;
    wait_to(b + 17);
    checks = checks + 1;
    if (dispensed_count === 8'd1 && busy === 1'b0) begin
      passes = passes + 1;
    end else begin
      $display("FAIL s1_final cyc=%0d got dc=%0d bz=%b required dc=1 bz=0", cyc, dispensed_count, busy);
    end

    // No cup at end of CUP: fault, queue during fault, clear with same-edge request.
    do_reset("s2_reset");
    b = cyc;
    cup_present  = 1'b0;
    dispense_req = 1'b1;
    for (int d = 1; d <= 4; d++) push(b + d, "s2_cup", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    push(b + 5, "s2_fault", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0);
    push(b + 6, "s2_fault_hold", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0);
    push(b + 7, "s2_fault_queue", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0);
    push(b + 8, "s2_clr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0);
    push(b + 9, "s2_restart", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0);
    wait_to(b + 1);
    dispense_req = 1'b0;
    wait_to(b + 6);
    dispense_req = 1'b1;
    wait_to(b + 7);
    fault_clr    = 1'b1;
    dispense_req = 1'b1;
    wait_to(b + 8);
    fault_clr    = 1'b0;
    dispense_req = 1'b0;
    wait_to(b + 10);

    // Five back-to-back requests: three queue, fifth overflows, four drinks total.
    do_reset("s3_reset");
    b = cyc;
    cup_present  = 1'b1;
    dispense_req = 1'b1;
    push(b + 1, "s3_start", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    push(b + 4, "s3_pend3", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'd0);
    push(b + 5, "s3_overflow", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 8'd0);
    push(b + 12, "s3_idle_q3", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 8'd1);
    push(b + 13, "s3_drink2", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 8'd1);
    push(b + 25, "s3_drink3", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 8'd2);
    push(b + 37, "s3_drink4", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'd3);
    push(b + 47, "s3_wait4", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'd4);
    push(b + 50, "s3_done", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd4);
    wait_to(b + 5);
    dispense_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = b + 1 + 12 * i;
      wait_to(e + 10);
      cup_present = 1'b0;
      wait_to(e + 11);
      cup_present = 1'b1;
    end
    wait_to(b + 51);
    checks = checks + 1;
    if (overflow === 1'b1 && dispensed_count === 8'd4) begin
      passes = passes + 1;
    end else begin
      $display("FAIL s3_final cyc=%0d got ov=%b dc=%0d required ov=1 dc=4", cyc, overflow, dispensed_count);
    end

    // Request on the same edge as a dequeue with pending=3.
    do_reset("s4_reset");
    b = cyc;
    cup_present  = 1'b1;
    dispense_req = 1'b1;
    push(b + 4, "s4_pend3", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'd0);
    push(b + 12, "s4_idle_q3", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'd1);
    push(b + 13, "s4_inc_dec", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'd1);
    wait_to(b + 4);
    dispense_req = 1'b0;
    wait_to(b + 11);
    cup_present = 1'b0;
    wait_to(b + 12);
    cup_present  = 1'b1;
    dispense_req = 1'b1;
    wait_to(b + 13);
    dispense_req = 1'b0;
    wait_to(b + 14);

    // Reset during the third pour cycle, with a request in the same cycle.
    do_reset("s5_reset");
    b = cyc;
    cup_present  = 1'b1;
    dispense_req = 1'b1;
    push(b + 7, "s5_pour3", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
    push(b + 8, "s5_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    push(b + 9, "s5_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
    wait_to(b + 1);
    dispense_req = 1'b0;
    wait_to(b + 7);
    rst          = 1'b1;
    dispense_req = 1'b1;
    wait_to(b + 8);
    rst          = 1'b0;
    dispense_req = 1'b0;
    wait_to(b + 10);
    checks = checks + 1;
    if (pour_valve === 1'b0 && busy === 1'b0 && pending === 2'd0 && dispensed_count === 8'd0) begin
      passes = passes + 1;
    end else begin
      $display("FAIL s5_final cyc=%0d got pv=%b bz=%b pd=%0d dc=%0d required pv=0 bz=0 pd=0 dc=0",
               cyc, pour_valve, busy, pending, dispensed_count);
    end

    // 256 drinks: counter reaches 255 then wraps to 0.
    do_reset("s6_reset");
    b = cyc;
    cup_present = 1'b1;
    for (int i = 0; i < 256; i++) begin
      e = b + 1 + 12 * i;
      if (i == 0)   push(e + 10, "s6_first", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd1);
      if (i == 254) push(e + 10, "s6_255", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd255);
      if (i == 255) begin
        push(e + 4, "s6_last_pour", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'd255);
        push(e + 10, "s6_wrap", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
        push(e + 12, "s6_wrap_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0);
      end
      wait_to(e - 1);
      dispense_req = 1'b1;
      wait_to(e);
      dispense_req = 1'b0;
      wait_to(e + 10);
      cup_present = 1'b0;
      wait_to(e + 11);
      cup_present = 1'b1;
    end
    wait_to(cyc + 3);
    checks = checks + 1;
    if (dispensed_count === 8'd0 && busy === 1'b0 && overflow === 1'b0) begin
      passes = passes + 1;
    end else begin
      $display("FAIL s6_final cyc=%0d got dc=%0d bz=%b ov=%b required dc=0 bz=0 ov=0",
               cyc, dispensed_count, busy, overflow);
    end

    while (sb.size() > 0) begin
      checks = checks + 1;
      $display("FAIL %s never_compared cyc=%0d required_cyc=%0d", sb[0].nm, cyc, sb[0].cyc);
      sb.delete(0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
